// File: rtl/fft_power_spectrum.sv
// fft_power_spectrum
// Power-spectrum stage that sits directly after the FFT core. It takes one
// frame of complex bins, each carrying a block exponent, and computes
// |X|^2 = re^2 + im^2. Each result is rescaled by the beat's block exponent
// and saturated to OUT_W bits, then re-emitted with a bin index and frame
// markers. Frame integrity is checked as beats arrive. Malformed frames are
// flagged on their last forwarded beat and counted.
//
// Build option: define FFT_PWR_HALF_SPECTRUM_EN to forward only bins
// 0..POINTS/2. Bin POINTS/2 then carries pwr_eop. The remaining input bins
// are still accepted and still checked. Without the macro, all POINTS bins
// are forwarded.
//
// Ports
//   clk, reset_n         clock; synchronous active-low reset
//   snk_valid/snk_ready  input handshake (snk_ready is combinational from pwr_ready)
//   snk_error            FFT error code, nonzero marks a bad beat
//   snk_sop/snk_eop      input frame start / end
//   snk_real/snk_imag    signed bin value
//   snk_exp              signed block exponent, valid with every beat
//   pwr_valid/pwr_ready  output handshake
//   pwr_data             scaled power, unsigned, saturating
//   pwr_bin              bin index of the output beat
//   pwr_sop/pwr_eop      output frame markers
//   pwr_err              set on the closing beat of a malformed frame
//   frame_cnt            completed good frames, wraps
//   err_cnt              malformed frames, saturates at 0xFFFF
module fft_power_spectrum #(
    parameter int DATA_W = 12,
    parameter int EXP_W  = 6,
    parameter int POINTS = 1024,
    parameter int IDX_W  = 10,
    parameter int OUT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     snk_valid,
    output logic                     snk_ready,
    input  logic [1:0]               snk_error,
    input  logic                     snk_sop,
    input  logic                     snk_eop,
    input  logic signed [DATA_W-1:0] snk_real,
    input  logic signed [DATA_W-1:0] snk_imag,
    input  logic signed [EXP_W-1:0]  snk_exp,
    output logic                     pwr_valid,
    input  logic                     pwr_ready,
    output logic [OUT_W-1:0]         pwr_data,
    output logic [IDX_W-1:0]         pwr_bin,
    output logic                     pwr_sop,
    output logic                     pwr_eop,
    output logic                     pwr_err,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              err_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(POINTS - 1);
`ifdef FFT_PWR_HALF_SPECTRUM_EN
    localparam bit               HALF_EN  = 1'b1;
    localparam logic [IDX_W-1:0] FWD_LAST = IDX_W'(POINTS / 2);
`else
    localparam bit               HALF_EN  = 1'b0;
    localparam logic [IDX_W-1:0] FWD_LAST = IDX_W'(POINTS - 1);
`endif

    // A left shift reaches 2*|e| <= 2**EXP_W. The wide word is sized so that
    // no bit is ever shifted out before the saturation test.
    localparam int SH_MAX = 2 ** EXP_W;
    localparam int P_W    = 2 * DATA_W;
    localparam int WIDE_W = P_W + SH_MAX;

    // Frame tracking state.
    logic [1:0]        state_reg, state_next;
    logic [IDX_W-1:0]  cnt_reg, cnt_next;
    logic              ferr_reg, ferr_next;
    logic [15:0]       frame_cnt_reg, err_cnt_reg;

    // Pipeline registers.
    logic                     s1_valid_reg, s1_sop_reg, s1_eop_reg, s1_err_reg;
    logic signed [DATA_W-1:0] s1_real_reg, s1_imag_reg;
    logic signed [EXP_W-1:0]  s1_exp_reg;
    logic [IDX_W-1:0]         s1_bin_reg;
    logic                     s2_valid_reg, s2_sop_reg, s2_eop_reg, s2_err_reg;
    logic [P_W-1:0]           s2_pwr_reg;
    logic signed [EXP_W-1:0]  s2_exp_reg;
    logic [IDX_W-1:0]         s2_bin_reg;
    logic                     s3_valid_reg, s3_sop_reg, s3_eop_reg, s3_err_reg;
    logic [OUT_W-1:0]         s3_data_reg;
    logic [IDX_W-1:0]         s3_bin_reg;

    logic adv, accept;
    assign adv       = !s3_valid_reg || pwr_ready;
    assign snk_ready = reset_n && adv;
    assign accept    = snk_valid && snk_ready;

    // Decisions made for the beat being accepted this cycle.
    logic             fwd, o_sop, o_eop, o_err, frame_inc, beat_err, frame_bad;
    logic [IDX_W-1:0] o_bin;
    logic [1:0]       err_inc;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ferr_next  = ferr_reg;
        fwd        = 1'b0;
        o_bin      = cnt_reg;
        o_sop      = 1'b0;
        o_eop      = 1'b0;
        o_err      = 1'b0;
        frame_inc  = 1'b0;
        err_inc    = 2'd0;
        beat_err   = |snk_error;
        frame_bad  = ferr_reg || beat_err;
        if (accept) begin
            if (snk_sop) begin
                // A sop inside a frame abandons the unterminated frame.
                if (state_reg == ST_FRAME) begin
                    err_inc = err_inc + 2'd1;
                end
                fwd   = 1'b1;
                o_bin = '0;
                o_sop = 1'b1;
                if (snk_eop) begin
                    // Single-beat frame: always short, so always malformed.
                    o_eop      = 1'b1;
                    o_err      = 1'b1;
                    err_inc    = err_inc + 2'd1;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    ferr_next  = 1'b0;
                end else begin
                    state_next = ST_FRAME;
                    cnt_next   = IDX_W'(1);
                    ferr_next  = beat_err;
                end
            end else if (state_reg == ST_FRAME) begin
                fwd   = (cnt_reg <= FWD_LAST);
                o_bin = cnt_reg;
                if (snk_eop) begin
                    o_eop      = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    ferr_next  = 1'b0;
                    if (cnt_reg == LAST_BIN && !frame_bad) begin
                        frame_inc = 1'b1;
                    end else begin
                        o_err   = 1'b1;
                        err_inc = err_inc + 2'd1;
                    end
                end else if (cnt_reg == LAST_BIN) begin
                    // Overlong frame: close it here and drop the excess.
                    o_eop      = 1'b1;
                    o_err      = 1'b1;
                    err_inc    = err_inc + 2'd1;
                    state_next = ST_DROP;
                    cnt_next   = '0;
                    ferr_next  = 1'b0;
                end else begin
                    cnt_next  = cnt_reg + IDX_W'(1);
                    ferr_next = frame_bad;
                    // Half spectrum: the output frame closes at the midpoint.
                    // Only errors seen so far can be reported on this beat.
                    if (HALF_EN && cnt_reg == FWD_LAST) begin
                        o_eop = 1'b1;
                        o_err = frame_bad;
                    end
                end
            end else if (state_reg == ST_DROP && snk_eop) begin
                state_next = ST_IDLE;
            end
        end
    end

    logic [16:0] err_sum;
    assign err_sum = {1'b0, err_cnt_reg} + 17'(err_inc);

    // S2 arithmetic: each square is at most 2**(P_W-2), so the sum fits in P_W bits.
    logic signed [P_W-1:0] re_ext, im_ext, sq_re, sq_im;
    logic [P_W-1:0]        pwr_sum;
    always_comb begin
        re_ext  = P_W'(s1_real_reg);
        im_ext  = P_W'(s1_imag_reg);
        sq_re   = re_ext * re_ext;
        sq_im   = im_ext * im_ext;
        pwr_sum = $unsigned(sq_re) + $unsigned(sq_im);
    end

    // S3 scaling: a negative exponent shifts left by 2|e|, otherwise shift right by 2e.
    logic signed [EXP_W:0] exp_ext;
    logic [EXP_W:0]        exp_mag;
    logic [EXP_W+1:0]      shamt;
    logic [WIDE_W-1:0]     wide_in, wide;
    logic [OUT_W-1:0]      scaled;
    always_comb begin
        exp_ext = (EXP_W + 1)'(s2_exp_reg);
        exp_mag = exp_ext[EXP_W] ? $unsigned(-exp_ext) : $unsigned(exp_ext);
        shamt   = {exp_mag, 1'b0};
        wide_in = {{SH_MAX{1'b0}}, s2_pwr_reg};
        wide    = exp_ext[EXP_W] ? (wide_in << shamt) : (wide_in >> shamt);
        scaled  = (|wide[WIDE_W-1:OUT_W]) ? {OUT_W{1'b1}} : wide[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            ferr_reg      <= 1'b0;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
            s1_valid_reg  <= 1'b0;
            s1_sop_reg    <= 1'b0;
            s1_eop_reg    <= 1'b0;
            s1_err_reg    <= 1'b0;
            s1_real_reg   <= '0;
            s1_imag_reg   <= '0;
            s1_exp_reg    <= '0;
            s1_bin_reg    <= '0;
            s2_valid_reg  <= 1'b0;
            s2_sop_reg    <= 1'b0;
            s2_eop_reg    <= 1'b0;
            s2_err_reg    <= 1'b0;
            s2_pwr_reg    <= '0;
            s2_exp_reg    <= '0;
            s2_bin_reg    <= '0;
            s3_valid_reg  <= 1'b0;
            s3_sop_reg    <= 1'b0;
            s3_eop_reg    <= 1'b0;
            s3_err_reg    <= 1'b0;
            s3_data_reg   <= '0;
            s3_bin_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ferr_reg      <= ferr_next;
            frame_cnt_reg <= frame_cnt_reg + 16'(frame_inc);
            err_cnt_reg   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (adv) begin
                s1_valid_reg <= accept && fwd;
                s1_sop_reg   <= o_sop;
                s1_eop_reg   <= o_eop;
                s1_err_reg   <= o_err;
                s1_real_reg  <= snk_real;
                s1_imag_reg  <= snk_imag;
                s1_exp_reg   <= snk_exp;
                s1_bin_reg   <= o_bin;
                s2_valid_reg <= s1_valid_reg;
                s2_sop_reg   <= s1_sop_reg;
                s2_eop_reg   <= s1_eop_reg;
                s2_err_reg   <= s1_err_reg;
                s2_pwr_reg   <= pwr_sum;
                s2_exp_reg   <= s1_exp_reg;
                s2_bin_reg   <= s1_bin_reg;
                s3_valid_reg <= s2_valid_reg;
                s3_sop_reg   <= s2_sop_reg;
                s3_eop_reg   <= s2_eop_reg;
                s3_err_reg   <= s2_err_reg;
                s3_data_reg  <= scaled;
                s3_bin_reg   <= s2_bin_reg;
            end
        end
    end

    assign pwr_valid = s3_valid_reg;
    assign pwr_data  = s3_data_reg;
    assign pwr_bin   = s3_bin_reg;
    assign pwr_sop   = s3_sop_reg;
    assign pwr_eop   = s3_eop_reg;
    assign pwr_err   = s3_err_reg;
    assign frame_cnt = frame_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_fft_power_spectrum.sv
// Testbench for fft_power_spectrum with POINTS=8. The expected output beats
// are queued when each input beat is accepted, and they are compared in order
// as the DUT emits them. The bench also checks the reset state, the counters,
// and that the outputs hold steady under backpressure. If the
// FFT_PWR_HALF_SPECTRUM_EN macro is defined, the expectations follow the
// half-spectrum build.
module tb_fft_power_spectrum;
    localparam int DATA_W = 12;
    localparam int EXP_W  = 6;
    localparam int POINTS = 8;
    localparam int IDX_W  = 3;
    localparam int OUT_W  = 32;
`ifdef FFT_PWR_HALF_SPECTRUM_EN
    localparam int LIM  = 4;
    localparam bit HALF = 1'b1;
`else
    localparam int LIM  = 7;
    localparam bit HALF = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     snk_valid = 1'b0;
    logic                     snk_ready;
    logic [1:0]               snk_error = 2'd0;
    logic                     snk_sop = 1'b0;
    logic                     snk_eop = 1'b0;
    logic signed [DATA_W-1:0] snk_real = '0;
    logic signed [DATA_W-1:0] snk_imag = '0;
    logic signed [EXP_W-1:0]  snk_exp = '0;
    logic                     pwr_valid;
    logic                     pwr_ready = 1'b1;
    logic [OUT_W-1:0]         pwr_data;
    logic [IDX_W-1:0]         pwr_bin;
    logic                     pwr_sop, pwr_eop, pwr_err;
    logic [15:0]              frame_cnt, err_cnt;

    fft_power_spectrum #(
        .DATA_W(DATA_W), .EXP_W(EXP_W), .POINTS(POINTS), .IDX_W(IDX_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_error(snk_error),
        .snk_sop(snk_sop), .snk_eop(snk_eop),
        .snk_real(snk_real), .snk_imag(snk_imag), .snk_exp(snk_exp),
        .pwr_valid(pwr_valid), .pwr_ready(pwr_ready), .pwr_data(pwr_data),
        .pwr_bin(pwr_bin), .pwr_sop(pwr_sop), .pwr_eop(pwr_eop), .pwr_err(pwr_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bin;
        logic        sop;
        logic        eop;
        logic        err;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    failures = 0;
    bit    toggle_en = 1'b0;
    int    exp_frames = 0;
    int    exp_errs = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference power: multiply or divide by 4 per exponent step, then clamp.
    function automatic longint ref_pwr(input int re, input int im, input int ex);
        longint p;
        longint sat;
        sat = 64'h0000_0000_FFFF_FFFF;
        p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        if (ex < 0) begin
            for (int i = 0; i < -ex; i++) begin
                p = p * 4;
                if (p > sat) p = sat;
            end
        end else begin
            p = p >> (2 * ex);
        end
        if (p > sat) p = sat;
        return p;
    endfunction

    // Output monitor: sample on the falling edge, away from the active edge.
    beat_t       exp_b;
    logic        stall_prev = 1'b0;
    logic [38:0] hold_prev = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check_value("hold", 64'({pwr_valid, pwr_data, pwr_bin, pwr_sop, pwr_eop, pwr_err}),
                            64'(hold_prev));
            if (pwr_valid && pwr_ready) begin
                $display("out bin=%0d data=0x%08h sop=%0b eop=%0b err=%0b",
                         pwr_bin, pwr_data, pwr_sop, pwr_eop, pwr_err);
                if (sb.size() == 0) begin
                    check_value("queue_depth", 64'(sb.size()), 64'd1);
                end else begin
                    exp_b = sb.pop_front();
                    check_value("data", 64'(pwr_data), 64'(exp_b.data));
                    check_value("bin_sop_eop_err", 64'({pwr_bin, pwr_sop, pwr_eop, pwr_err}),
                                64'({exp_b.bin, exp_b.sop, exp_b.eop, exp_b.err}));
                end
            end
            stall_prev = pwr_valid && !pwr_ready;
            hold_prev  = {pwr_valid, pwr_data, pwr_bin, pwr_sop, pwr_eop, pwr_err};
        end
    end

    // Sole driver of pwr_ready: toggles every cycle when enabled, high otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pwr_ready = toggle_en ? !pwr_ready : 1'b1;
        end
    end

    // Present one beat, wait for acceptance, queue its expected output if forwarded.
    task automatic send(input logic s, input logic e, input int re, input int im, input int ex,
                        input logic [1:0] er, input bit fwd, input int obin,
                        input bit osop, input bit oeop, input bit oerr);
        int    n;
        beat_t b;
        snk_valid = 1'b1;
        snk_sop   = s;
        snk_eop   = e;
        snk_real  = re[DATA_W-1:0];
        snk_imag  = im[DATA_W-1:0];
        snk_exp   = ex[EXP_W-1:0];
        snk_error = er;
        @(negedge clk);
        n = 0;
        while (!snk_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!snk_ready) begin
            check_value("ready_timeout", 64'(snk_ready), 64'd1);
        end else if (fwd) begin
            b.data = 32'(ref_pwr(re, im, ex));
            b.bin  = obin[2:0];
            b.sop  = osop;
            b.eop  = oeop;
            b.err  = oerr;
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
        snk_valid = 1'b0;
        snk_error = 2'd0;
    endtask

    // n beats with sop on beat 0, eop on beat eop_at (-1: none), error code on err_bin (-1: none).
    task automatic send_frame(input int n, input int eop_at, input int re, input int im,
                              input int ex, input int err_bin);
        bit ended, eop, sop, ferr, fwd, oeop, oerr;
        ended = 1'b0;
        for (int b = 0; b < n; b++) begin
            eop  = (b == eop_at);
            sop  = (b == 0);
            ferr = (err_bin >= 0) && (err_bin <= b);
            fwd  = !ended && (b <= LIM);
            oeop = fwd && (eop || b == LIM);
            oerr = oeop && (ferr || (eop && b != POINTS - 1) || (!eop && !HALF));
            send(sop, eop, re, im, ex, (b == err_bin) ? 2'd1 : 2'd0, fwd, b, sop, oeop, oerr);
            if (eop || b == POINTS - 1) ended = 1'b1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check_value("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_counters();
        check_value("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        check_value("err_cnt", 64'(err_cnt), 64'(exp_errs));
    endtask

    int sat_exp[8] = '{-5, -4, 0, 31, -32, -1, 5, 3};

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_pwr_valid", 64'(pwr_valid), 64'd0);
        check_value("rst_pwr_data", 64'(pwr_data), 64'd0);
        check_value("rst_pwr_flags", 64'({pwr_bin, pwr_sop, pwr_eop, pwr_err}), 64'd0);
        check_value("rst_snk_ready", 64'(snk_ready), 64'd0);
        check_counters();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_value("post_rst_snk_ready", 64'(snk_ready), 64'd1);
        check_value("post_rst_pwr_valid", 64'(pwr_valid), 64'd0);
        @(posedge clk);
        #1;

        // Good frames, re=3 im=-4: e=0 -> 25, e=-2 -> 400, e=1 -> 6.
        send_frame(8, 7, 3, -4, 0, -1);
        send_frame(8, 7, 3, -4, -2, -1);
        send_frame(8, 7, 3, -4, 1, -1);
        exp_frames = 3;
        drain();
        check_counters();

        // Full-scale inputs across exponent extremes, including saturation.
        for (int b = 0; b < 8; b++)
            send(b == 0, b == 7, -2048, -2048, sat_exp[b], 2'd0, b <= LIM, b, b == 0, b == LIM, 1'b0);
        exp_frames = 4;

        // Early eop on bin 4, then a good frame.
        send_frame(5, 4, 7, 1, 0, -1);
        exp_errs = 1;
        send_frame(8, 7, 1, 1, -3, -1);
        exp_frames = 5;
        drain();
        check_counters();

        // Ten beats with no eop: forced close at bin 7, two beats dropped.
        send_frame(10, -1, 5, 5, 0, -1);
        exp_errs = 2;
        send_frame(8, 7, -9, 2, 2, -1);
        exp_frames = 6;
        drain();
        check_counters();

        // Error code on bin 2 and on bin 6.
        send_frame(8, 7, 11, -3, 0, 2);
        send_frame(8, 7, 11, -3, 0, 6);
        exp_errs = 4;
        drain();
        check_counters();

        // sop inside a frame, then a single-beat sop+eop frame.
        send_frame(4, -1, 2, 2, 0, -1);
        send_frame(8, 7, 2, 3, -1, -1);
        exp_errs = 5;
        exp_frames = 7;
        send_frame(1, 0, 100, 100, 0, -1);
        exp_errs = 6;
        // Non-sop beats while idle are discarded.
        send(1'b0, 1'b0, 9, 9, 0, 2'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 9, 9, 0, 2'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        send_frame(8, 7, -1000, 700, 2, -1);
        exp_frames = 8;
        drain();
        check_counters();

        // Backpressure: pwr_ready toggles every cycle.
        toggle_en = 1'b1;
        send_frame(8, 7, 100, -50, -1, -1);
        exp_frames = 9;
        drain();
        toggle_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_counters();

        // Reset mid-frame: in-flight beats are lost and the counters clear.
        send(1'b1, 1'b0, 4, 4, 0, 2'd0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 4, 4, 0, 2'd0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 4, 4, 0, 2'd0, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        exp_frames = 0;
        exp_errs = 0;
        check_value("midrst_pwr_valid", 64'(pwr_valid), 64'd0);
        check_counters();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_frame(8, 7, 3, -4, 0, -1);
        exp_frames = 1;
        drain();
        check_counters();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
